// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer slice.
package count_seq_pkg;

  // Default counter / limit width in bits
  localparam int unsigned DEF_WIDTH = 3;

  // Run-controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_counter.sv
// WIDTH-bit up-counter register with clear, hold and enable controls.
// Control priority: reset > clear > hold > enable.
module seq_counter
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  // Counter register; arithmetic wraps modulo 2^WIDTH
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (hold) begin
      count <= count;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run controller for a small binary counter: start/pause/abort commands,
// one-shot or continuous mode, registered busy/done/wrap/error status.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             error
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;

  logic             latch_c;
  logic             cnt_clear_c;
  logic             cnt_enable_c;
  logic             cnt_hold_c;
  logic             busy_d;
  logic             done_d;
  logic             wrap_d;
  logic             error_d;

  // Counter datapath, steered by the FSM below
  seq_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear_c),
    .enable (cnt_enable_c),
    .hold   (cnt_hold_c),
    .count  (count)
  );

  // State, run configuration and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      mode_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_c) begin
        limit_q <= limit;
        mode_q  <= mode;
      end
      busy    <= busy_d;
      done    <= done_d;
      wrap    <= wrap_d;
      error   <= error_d;
    end
  end

  // Next state, counter controls and next status; abort > pause > start
  always_comb begin
    state_d      = state_q;
    latch_c      = 1'b0;
    cnt_clear_c  = 1'b0;
    cnt_enable_c = 1'b0;
    cnt_hold_c   = 1'b0;
    done_d       = 1'b0;
    wrap_d       = 1'b0;
    error_d      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      cnt_clear_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !pause) begin
            if (limit != '0) begin
              latch_c     = 1'b1;
              cnt_clear_c = 1'b1;
              state_d     = ST_RUN;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            // Pause also defers a pending terminal action until resume
            state_d    = ST_PAUSE;
            cnt_hold_c = 1'b1;
          end else if (count == limit_q) begin
            if (mode_q) begin
              cnt_clear_c = 1'b1;
              wrap_d      = 1'b1;
            end else begin
              state_d    = ST_DONE;
              done_d     = 1'b1;
              cnt_hold_c = 1'b1;
            end
          end else begin
            cnt_enable_c = 1'b1;
          end
        end
        ST_PAUSE: begin
          cnt_hold_c = 1'b1;
          if (start && !pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          cnt_hold_c = 1'b1;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus random
// commands, every cycle compared against a behavioural reference model.
module tb_count_sequencer;

  localparam int unsigned W   = 3;
  localparam int          MOD = 1 << W;

  logic         clock;
  logic         reset;
  logic         start;
  logic         pause;
  logic         abort;
  logic         mode;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         wrap;
  logic         error;

  count_sequencer #(
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .pause (pause),
    .abort (abort),
    .mode  (mode),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap),
    .error (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Single comparison point: count it and report any mismatch
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: run phases described as plain integers
  localparam int PH_IDLE   = 0;
  localparam int PH_RUN    = 1;
  localparam int PH_PAUSED = 2;
  localparam int PH_FINISH = 3;

  int m_phase = PH_IDLE;
  int m_count = 0;
  int m_limit = 0;
  int m_cont  = 0;
  int e_busy, e_done, e_wrap, e_err;

  task automatic model_step(input bit r, input bit s, input bit p, input bit a,
                            input bit m, input int l);
    e_done = 0;
    e_wrap = 0;
    e_err  = 0;
    if (r) begin
      m_phase = PH_IDLE;
      m_count = 0;
      m_limit = 0;
      m_cont  = 0;
    end else if (a) begin
      m_phase = PH_IDLE;
      m_count = 0;
    end else if (m_phase == PH_IDLE) begin
      if (s && !p) begin
        if (l == 0) begin
          e_err = 1;
        end else begin
          m_limit = l;
          m_cont  = m;
          m_count = 0;
          m_phase = PH_RUN;
        end
      end
    end else if (m_phase == PH_RUN) begin
      if (p) begin
        m_phase = PH_PAUSED;
      end else if (m_count != m_limit) begin
        m_count = (m_count + 1) % MOD;
      end else if (m_cont != 0) begin
        m_count = 0;
        e_wrap  = 1;
      end else begin
        m_phase = PH_FINISH;
        e_done  = 1;
      end
    end else if (m_phase == PH_PAUSED) begin
      if (s && !p) m_phase = PH_RUN;
    end else begin
      m_phase = PH_IDLE;
    end
    e_busy = (m_phase == PH_RUN || m_phase == PH_PAUSED) ? 1 : 0;
  endtask

  // One clock cycle: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input bit r, input bit s, input bit p, input bit a,
                     input bit m, input int l);
    reset = r;
    start = s;
    pause = p;
    abort = a;
    mode  = m;
    limit = W'(l);
    @(posedge clock);
    model_step(r, s, p, a, m, l);
    @(negedge clock);
    check("count", int'(count), m_count);
    check("busy",  int'(busy),  e_busy);
    check("done",  int'(done),  e_done);
    check("wrap",  int'(wrap),  e_wrap);
    check("error", int'(error), e_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    limit = '0;
    @(negedge clock);

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 5);
    idle(1);

    // One-shot run to 5, then idle keeps count at 5
    cyc(0, 1, 0, 0, 0, 5);
    idle(8);
    check("oneshot_final_count", int'(count), 5);
    check("oneshot_final_busy", int'(busy), 0);

    // Continuous run with limit 2; start during RUN is ignored
    cyc(0, 1, 0, 0, 1, 2);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Pause at count 2, hold three cycles, resume
    cyc(0, 1, 0, 0, 0, 4);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    check("paused_busy", int'(busy), 1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(5);

    // Zero limit is rejected
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);

    // Abort beats pause mid-run
    cyc(0, 1, 0, 0, 1, 7);
    idle(3);
    cyc(0, 0, 1, 1, 0, 0);
    check("abort_count", int'(count), 0);
    idle(1);

    // Reset mid-run
    cyc(0, 1, 0, 0, 1, 7);
    idle(4);
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);

    // Limit/mode changes during RUN do not affect the run
    cyc(0, 1, 0, 0, 0, 6);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 1);

    // Full-range continuous run: natural rollover still flags wrap
    cyc(0, 1, 0, 0, 1, 7);
    idle(18);
    cyc(0, 0, 0, 1, 0, 0);

    // Randomized commands
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(299) == 0),
          ($urandom_range(3) == 0),
          ($urandom_range(7) == 0),
          ($urandom_range(39) == 0),
          1'($urandom_range(1)),
          int'($urandom_range(MOD - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Run controller for the small binary counters used in the sequential examples.
- Accepts start/pause/abort commands and a programmable terminal value (limit).
- Sequences an internal WIDTH-bit up-counter in one-shot or continuous mode.
- Reports busy, done, wrap and error status to the surrounding test or display logic.

Parameters:
- WIDTH, 3, counter and limit width in bits.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run (IDLE) or resume (PAUSE).
- pause  input  1  freeze counting while in RUN.
- abort  input  1  cancel from any state.
- mode  input  1  0 = one-shot, 1 = continuous; latched at start.
- limit  input  WIDTH  terminal count; latched at start.
- count  output  WIDTH  current counter value.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse; one-shot run completed.
- wrap  output  1  one-cycle pulse; continuous run wrapped.
- error  output  1  one-cycle pulse; start rejected.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, count 0, limit_q 0, mode_q 0; busy, done, wrap, error all 0.
- Reset dominates every input, including mid-run; the block is in IDLE the cycle after reset.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority each cycle: abort > pause > start.
- abort in any state: next cycle IDLE, count 0, all pulses 0.
- IDLE with start=1 and limit!=0:
  - latch limit_q and mode_q;
  - next cycle RUN, count 0, busy 1.
- IDLE with start=1 and limit==0: stay IDLE, error=1 for one cycle, count unchanged.
- IDLE otherwise: count holds its last value.
- RUN with count != limit_q: count increments by 1.
- RUN with count == limit_q, mode_q=0: next cycle DONE, count held at limit_q, done=1, busy=0.
- RUN with count == limit_q, mode_q=1: count wraps to 0 and wrap=1 in the same next cycle; state stays RUN.
- RUN with pause=1: next cycle PAUSE, count frozen.
  - Applies even when count == limit_q; the terminal action is deferred until resume.
- PAUSE with start=1: next cycle RUN.
  - Counting resumes from the frozen value; the first increment appears one cycle later.
- PAUSE otherwise: hold.
- start while in RUN: ignored; no error.
- DONE: lasts exactly one cycle, then IDLE; count keeps limit_q. start during DONE is ignored.
- limit and mode changes outside IDLE have no effect.
- Latency: start in cycle N produces:
  - RUN with count=0 at N+1;
  - count=k at N+1+k;
  - done at N+2+limit (one-shot);
  - first wrap at N+2+limit (continuous).
- Arithmetic is modulo 2^WIDTH. limit_q = 2^WIDTH-1 gives natural rollover, with wrap still flagged.

Decomposition:
- Package count_seq_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the default WIDTH constant.
- Sub-module seq_counter contains the WIDTH-bit register with clear, enable and hold controls.
- The FSM stays in count_sequencer and drives seq_counter's controls.

Test Plan:
- Reset, then start with limit=5, mode=0 -> count 0,1,2,3,4,5 over six RUN cycles; DONE with count=5, done=1 for one cycle; then IDLE with busy=0 and count still 5.
- start with limit=2, mode=1, run 9 cycles -> count 0,1,2,0,1,2,0,1,2; wrap=1 exactly in the cycles where count returns to 0; done never asserts.
- limit=4, mode=0, pause when count=2, hold 3 cycles, then start -> count stays 2 while paused; then 3,4; done follows; busy stays 1 throughout the pause.
- start with limit=0 -> error=1 for one cycle, state stays IDLE, busy=0, count unchanged.
- limit=7, mode=1, abort and pause asserted together at count=3 -> abort wins: next cycle IDLE, count 0, busy 0. Reset asserted mid-run -> same result plus all pulses 0.
- limit=6 start, change limit to 1 and mode to 1 during RUN -> run still ends at count=6 with done=1 and no wrap.
